// File: rtl/accel_spi_reader_if.sv
// SPI bus between the accelerometer reader (master) and the ADXL345 (slave).
interface accel_spi_reader_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/accel_spi_reader.sv
// ADXL345 SPI master: configures the sensor after power-up, then burst-reads X/Y
// on each sample request and presents raw[9:2] of both axes to the game logic.
module accel_spi_reader #(
  parameter int CLK_DIV        = 9,
  parameter int POWERUP_CYCLES = 72000,
  parameter int CS_GAP         = 18
) (
  input  logic                pixel_clk,
  input  logic                rst_n,
  input  logic                sample_req,
  output logic [7:0]          accel_data_x,
  output logic [7:0]          accel_data_y,
  output logic                data_valid,
  output logic                init_done,
  output logic                busy,
  accel_spi_reader_if.master  spi
);

  localparam int CNT_MAX = (POWERUP_CYCLES > CS_GAP) ? POWERUP_CYCLES : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    PWRUP, WR_FMT, WR_PWR, GAP, IDLE, RD
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       half_q, half_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             pending_q, pending_d;
  logic             init_done_q, init_done_d;
  logic             valid_q, valid_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [15:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic [6:0]       end_half;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      ret_q       <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      half_q      <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      half_q      <= half_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // Shift registers carry only data; their contents are reloaded at every frame start.
  always_ff @(posedge pixel_clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  // A frame is 2*bits half-periods plus one trailing half-period before cs_n rises.
  assign end_half = (state_q == RD) ? 7'd80 : 7'd32;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    half_d      = half_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    pending_d   = pending_q | sample_req;
    init_done_d = init_done_q;
    valid_d     = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    tx_d        = tx_q;
    rx_d        = rx_q;

    unique case (state_q)
      PWRUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PWR_LAST) begin
          state_d = WR_FMT;
          cs_n_d  = 1'b0;
          div_d   = '0;
          half_d  = '0;
          tx_d    = 16'h3100;
        end
      end

      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          if (ret_q == WR_PWR) begin
            state_d = WR_PWR;
            cs_n_d  = 1'b0;
            div_d   = '0;
            half_d  = '0;
            tx_d    = 16'h2D08;
          end else begin
            state_d = IDLE;
          end
        end
      end

      IDLE: begin
        if (pending_q) begin
          // A request landing in this very cycle survives the clear.
          pending_d = sample_req;
          state_d   = RD;
          cs_n_d    = 1'b0;
          div_d     = '0;
          half_d    = '0;
          tx_d      = 16'hF200;
        end
      end

      WR_FMT, WR_PWR, RD: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          if (half_q == end_half) begin
            cs_n_d  = 1'b1;
            state_d = GAP;
            cnt_d   = '0;
            ret_d   = (state_q == WR_FMT) ? WR_PWR : IDLE;
            if (state_q == WR_PWR) init_done_d = 1'b1;
            if (state_q == RD) begin
              x_d     = {rx_q[17:16], rx_q[31:26]};
              y_d     = {rx_q[1:0],   rx_q[15:10]};
              valid_d = 1'b1;
            end
          end else if (!half_q[0]) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], spi.spi_miso};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = PWRUP;
    endcase
  end

  assign accel_data_x = x_q;
  assign accel_data_y = y_q;
  assign data_valid   = valid_q;
  assign init_done    = init_done_q;
  assign busy         = ((state_q != IDLE) && (state_q != PWRUP)) ||
                        ((state_q == IDLE) && pending_q);
  assign spi.spi_cs_n = cs_n_q;
  assign spi.spi_sclk = sclk_q;
  assign spi.spi_mosi = mosi_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Directed bench for accel_spi_reader: ADXL345 slave model, framing monitor and
// hand-computed X/Y results.
module tb_accel_spi_reader;

  localparam int P = 300;

  logic       pixel_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_req = 1'b0;
  logic [7:0] accel_data_x, accel_data_y;
  logic       data_valid, init_done, busy;

  accel_spi_reader_if spi_if ();

  accel_spi_reader #(.CLK_DIV(9), .POWERUP_CYCLES(P), .CS_GAP(18)) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .sample_req   (sample_req),
    .accel_data_x (accel_data_x),
    .accel_data_y (accel_data_y),
    .data_valid   (data_valid),
    .init_done    (init_done),
    .busy         (busy),
    .spi          (spi_if)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model and framing monitor, sampled on the falling pixel_clk edge.
  logic [39:0] rx_pat = '0;
  logic [39:0] fdata = '0, frame_data = '0;
  int          fbits = 0, frame_bits = 0, frame_cnt = 0, nfall = 0;
  int          cyc = 0, last_evt = 0, rise_cyc = 0, last_gap = 0;
  int          dv_cnt = 0;
  logic [7:0]  last_x = '0, last_y = '0;
  logic        prev_cs = 1'b1, prev_sc = 1'b1, prev_mo = 1'b0, prev_dv = 1'b0;
  logic        init_at_rise = 1'b0;

  initial spi_if.spi_miso = 1'b0;

  always @(negedge pixel_clk) begin
    cyc++;
    if (prev_cs && !spi_if.spi_cs_n) begin
      fbits = 0; fdata = '0; nfall = 0; last_evt = cyc;
      last_gap = cyc - rise_cyc;
    end
    if (!spi_if.spi_cs_n && (spi_if.spi_sclk != prev_sc)) begin
      check("half_period", 64'(cyc - last_evt), 64'd9);
      last_evt = cyc;
      if (!spi_if.spi_sclk) begin
        if (nfall < 40) spi_if.spi_miso = rx_pat[39 - nfall];
        nfall++;
      end else begin
        check("mosi_on_rise", 64'(spi_if.spi_mosi), 64'(prev_mo));
        fdata = {fdata[38:0], spi_if.spi_mosi};
        fbits++;
      end
    end
    if (!prev_cs && spi_if.spi_cs_n) begin
      frame_bits = fbits; frame_data = fdata; frame_cnt++;
      rise_cyc = cyc; init_at_rise = init_done;
    end
    if (data_valid) begin
      dv_cnt++;
      last_x = accel_data_x; last_y = accel_data_y;
      check("dv_with_cs_rise", 64'(!prev_cs && spi_if.spi_cs_n), 64'd1);
      check("dv_single", 64'(prev_dv), 64'd0);
    end
    prev_cs = spi_if.spi_cs_n; prev_sc = spi_if.spi_sclk;
    prev_mo = spi_if.spi_mosi; prev_dv = data_valid;
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge pixel_clk); n++;
    end
    check("frame_timeout", 64'(frame_cnt >= target), 64'd1);
  endtask

  task automatic pulse_req();
    @(negedge pixel_clk) sample_req = 1'b1;
    @(negedge pixel_clk) sample_req = 1'b0;
  endtask

  task automatic release_and_init();
    int n = 0;
    int f0;
    f0 = frame_cnt;
    @(negedge pixel_clk) rst_n = 1'b1;
    while (spi_if.spi_cs_n && n < P + 50) begin
      @(negedge pixel_clk); n++;
    end
    check("powerup_len", 64'(n), 64'(P));
    wait_frames(f0 + 1, 1000);
    check("fmt_bits", 64'(frame_bits), 64'd16);
    check("fmt_data", 64'(frame_data[15:0]), 64'h3100);
    check("init_after_fmt", 64'(init_at_rise), 64'd0);
    wait_frames(f0 + 2, 1000);
    check("pwr_bits", 64'(frame_bits), 64'd16);
    check("pwr_data", 64'(frame_data[15:0]), 64'h2D08);
    check("init_after_pwr", 64'(init_at_rise), 64'd1);
    check("cfg_gap_min", 64'(last_gap >= 18), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] pat, input logic [7:0] ex, input logic [7:0] ey);
    int f0, d0;
    f0 = frame_cnt; d0 = dv_cnt;
    rx_pat = {8'h00, pat};
    pulse_req();
    wait_frames(f0 + 1, 1500);
    check("rd_bits", 64'(frame_bits), 64'd40);
    check("rd_cmd", 64'(frame_data[39:32]), 64'hF2);
    check("rd_mosi_zero", 64'(frame_data[31:0]), 64'h0);
    check("rd_x", 64'(last_x), 64'(ex));
    check("rd_y", 64'(last_y), 64'(ey));
    check("rd_dv_count", 64'(dv_cnt - d0), 64'd1);
  endtask

  initial begin
    int f0, d0, n;
    repeat (3) @(negedge pixel_clk);
    check("rst_cs_n", 64'(spi_if.spi_cs_n), 64'd1);
    check("rst_sclk", 64'(spi_if.spi_sclk), 64'd1);
    check("rst_mosi", 64'(spi_if.spi_mosi), 64'd0);
    check("rst_xy", 64'({accel_data_x, accel_data_y}), 64'd0);
    check("rst_dv_init_busy", 64'({data_valid, init_done, busy}), 64'd0);

    release_and_init();
    repeat (30) @(negedge pixel_clk);
    check("idle_busy", 64'(busy), 64'd0);

    do_read(32'h5401_FC03, 8'h55, 8'hFF);
    repeat (30) @(negedge pixel_clk);
    do_read(32'h0002_8000, 8'h80, 8'h20);
    repeat (30) @(negedge pixel_clk);

    // Three requests during one read collapse into exactly one follow-up read.
    f0 = frame_cnt; d0 = dv_cnt;
    rx_pat = {8'h00, 32'h5401_FC03};
    pulse_req();
    n = 0;
    while (spi_if.spi_cs_n && n < 100) begin @(negedge pixel_clk); n++; end
    check("triple_start", 64'(spi_if.spi_cs_n), 64'd0);
    pulse_req();
    repeat (100) @(negedge pixel_clk);
    pulse_req();
    repeat (200) @(negedge pixel_clk);
    pulse_req();
    wait_frames(f0 + 2, 3000);
    repeat (1500) @(negedge pixel_clk);
    check("triple_frames", 64'(frame_cnt - f0), 64'd2);
    check("triple_dv", 64'(dv_cnt - d0), 64'd2);
    check("triple_idle", 64'(busy), 64'd0);

    // Request during power-up is held and served right after configuration.
    @(negedge pixel_clk) rst_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    f0 = frame_cnt; d0 = dv_cnt;
    rx_pat = {8'h00, 32'h5401_FC03};
    @(negedge pixel_clk) rst_n = 1'b1;
    repeat (5) @(negedge pixel_clk);
    pulse_req();
    check("pwrup_req_busy", 64'(busy), 64'd0);
    wait_frames(f0 + 3, P + 3000);
    check("early_rd_bits", 64'(frame_bits), 64'd40);
    check("early_init", 64'(init_done), 64'd1);
    check("early_dv", 64'(dv_cnt - d0), 64'd1);
    check("early_x", 64'(last_x), 64'h55);
    repeat (30) @(negedge pixel_clk);

    // Reset at bit 20 of a read aborts it cleanly and replays configuration.
    d0 = dv_cnt;
    pulse_req();
    n = 0;
    while (!(fbits == 20 && !spi_if.spi_cs_n) && n < 1000) begin @(negedge pixel_clk); n++; end
    check("abort_reached", 64'(fbits), 64'd20);
    rst_n = 1'b0;
    @(negedge pixel_clk);
    check("abort_cs_n", 64'(spi_if.spi_cs_n), 64'd1);
    check("abort_sclk", 64'(spi_if.spi_sclk), 64'd1);
    check("abort_xy", 64'({accel_data_x, accel_data_y}), 64'd0);
    check("abort_dv", 64'(data_valid), 64'd0);
    repeat (3) @(negedge pixel_clk);
    check("abort_no_dv", 64'(dv_cnt - d0), 64'd0);
    check("abort_init", 64'(init_done), 64'd0);
    release_and_init();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
